// File: rtl/wb_write_arbiter_if.sv
// Writeback bundle: ALU/load producers, regfile write port,
// and pending-write lookups for decode.
interface wb_write_arbiter_if #(
  parameter int REG_ADDR_LEN = 5,
  parameter int REG_LEN      = 32
);
  logic                    alu_valid;
  logic                    alu_ready;
  logic [REG_ADDR_LEN-1:0] alu_rd;
  logic [REG_LEN-1:0]      alu_data;
  logic                    ld_valid;
  logic [REG_ADDR_LEN-1:0] ld_rd;
  logic [REG_LEN-1:0]      ld_data;
  logic                    write_enable;
  logic [REG_ADDR_LEN-1:0] write_addr;
  logic [REG_LEN-1:0]      write_data;
  logic [REG_ADDR_LEN-1:0] query_addr1;
  logic                    query_hit1;
  logic [REG_ADDR_LEN-1:0] query_addr2;
  logic                    query_hit2;
  logic                    busy;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output query_addr1, query_addr2,
    input  alu_ready,
    input  write_enable, write_addr, write_data,
    input  query_hit1, query_hit2, busy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  query_addr1, query_addr2,
    output alu_ready,
    output write_enable, write_addr, write_data,
    output query_hit1, query_hit2, busy
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Regfile write-port arbiter: loads always win, ALU results
// that lose wait in an in-order skid FIFO.
module wb_write_arbiter #(
  parameter int REG_ADDR_LEN = 5,
  parameter int REG_LEN      = 32,
  parameter int FIFO_DEPTH   = 2
) (
  input logic               clk,
  input logic               rst,
  wb_write_arbiter_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [REG_ADDR_LEN-1:0] q_rd   [FIFO_DEPTH];
  logic [REG_LEN-1:0]      q_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   q_vld;
  logic [PW-1:0]           head;
  logic [PW-1:0]           tail;
  logic [CW-1:0]           count;

  logic                    empty;
  logic                    alu_acc;
  logic                    alu_live;
  logic                    ld_live;
  logic                    sel_ld;
  logic                    sel_pop;
  logic                    sel_byp;
  logic                    issue;
  logic                    push;
  logic                    pop;
  logic [REG_ADDR_LEN-1:0] iss_rd;
  logic [REG_LEN-1:0]      iss_data;
  logic                    hit1;
  logic                    hit2;

  logic                    we_q;
  logic [REG_ADDR_LEN-1:0] wa_q;
  logic [REG_LEN-1:0]      wd_q;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign bus.alu_ready = rst && (count < FULL);
  assign alu_acc  = bus.alu_valid && bus.alu_ready;
  assign alu_live = alu_acc && (bus.alu_rd != '0);
  assign ld_live  = bus.ld_valid && (bus.ld_rd != '0);

  // Mutually exclusive selects; bypass only when nothing is queued
  assign sel_ld  = ld_live;
  assign sel_pop = !ld_live && !empty;
  assign sel_byp = !ld_live && empty && alu_live;

  always_comb begin
    issue    = 1'b0;
    pop      = 1'b0;
    iss_rd   = '0;
    iss_data = '0;
    unique case (1'b1)
      sel_ld: begin
        issue    = 1'b1;
        iss_rd   = bus.ld_rd;
        iss_data = bus.ld_data;
      end
      sel_pop: begin
        issue    = 1'b1;
        pop      = 1'b1;
        iss_rd   = q_rd[head];
        iss_data = q_data[head];
      end
      sel_byp: begin
        issue    = 1'b1;
        iss_rd   = bus.alu_rd;
        iss_data = bus.alu_data;
      end
      default: ;
    endcase
  end

  assign push = alu_live && !sel_byp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      q_vld <= '0;
    end else begin
      if (push) begin
        q_vld[tail] <= 1'b1;
        tail        <= nxt(tail);
      end
      if (pop) begin
        q_vld[head] <= 1'b0;
        head        <= nxt(head);
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[tail]   <= bus.alu_rd;
      q_data[tail] <= bus.alu_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
    end else begin
      we_q <= issue;
      if (issue) begin
        wa_q <= iss_rd;
        wd_q <= iss_data;
      end
    end
  end

  assign bus.write_enable = we_q;
  assign bus.write_addr   = wa_q;
  assign bus.write_data   = wd_q;

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (q_vld[i] && q_rd[i] == bus.query_addr1)
        hit1 = 1'b1;
      if (q_vld[i] && q_rd[i] == bus.query_addr2)
        hit2 = 1'b1;
    end
  end

  assign bus.query_hit1 = hit1 && (bus.query_addr1 != '0);
  assign bus.query_hit2 = hit2 && (bus.query_addr2 != '0);
  assign bus.busy       = !empty;

  overflow_a: assert property (
    @(posedge clk) disable iff (!rst)
    !(push && count == FULL)
  );

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: bypass, collision,
// back-pressure, x0 filtering and async reset.
module tb_wb_write_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   k;
  logic acc;

  logic [4:0]  exp_addr [8] = '{5'd10, 5'd11, 5'd12, 5'd13,
                                5'd1, 5'd2, 5'd3, 5'd4};
  logic [31:0] exp_data [8] = '{32'h10a, 32'h10b, 32'h10c,
                                32'h10d, 32'h201, 32'h202,
                                32'h203, 32'h204};
  logic        exp_rdy  [7] = '{1'b1, 1'b1, 1'b0, 1'b0,
                                1'b0, 1'b1, 1'b1};

  wb_write_arbiter_if #(.REG_ADDR_LEN(5), .REG_LEN(32)) bus ();

  wb_write_arbiter #(
    .REG_ADDR_LEN(5),
    .REG_LEN(32),
    .FIFO_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] a,
                        input logic [31:0] d);
    chk({tag, "_we"}, 32'(bus.write_enable), 32'd1);
    chk({tag, "_addr"}, 32'(bus.write_addr), 32'(a));
    chk({tag, "_data"}, bus.write_data, d);
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_rd     = '0;
    bus.ld_data   = '0;
  endtask

  initial begin
    idle();
    bus.query_addr1 = 5'd3;
    bus.query_addr2 = 5'd0;
    #2;
    chk("rst_we", 32'(bus.write_enable), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ready", 32'(bus.alu_ready), 32'd0);
    chk("rst_hit1", 32'(bus.query_hit1), 32'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("rel_ready", 32'(bus.alu_ready), 32'd1);

    // ALU alone: bypass with one-cycle latency
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd3;
    bus.alu_data  = 32'h11;
    tick();
    idle();
    chk_wr("alu", 5'd3, 32'h11);
    chk("alu_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("alu_we_drop", 32'(bus.write_enable), 32'd0);

    // Collision: load wins, ALU waits one cycle
    bus.ld_valid    = 1'b1;
    bus.ld_rd       = 5'd5;
    bus.ld_data     = 32'hAA;
    bus.alu_valid   = 1'b1;
    bus.alu_rd      = 5'd6;
    bus.alu_data    = 32'hBB;
    bus.query_addr1 = 5'd6;
    bus.query_addr2 = 5'd5;
    tick();
    idle();
    chk_wr("col_ld", 5'd5, 32'hAA);
    chk("col_hit1", 32'(bus.query_hit1), 32'd1);
    chk("col_hit2", 32'(bus.query_hit2), 32'd0);
    chk("col_busy", 32'(bus.busy), 32'd1);
    chk("col_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    chk_wr("col_alu", 5'd6, 32'hBB);
    chk("col_hit1_clr", 32'(bus.query_hit1), 32'd0);
    chk("col_busy_clr", 32'(bus.busy), 32'd0);
    tick();
    chk("col_we_drop", 32'(bus.write_enable), 32'd0);

    // Back-pressure: 4 loads, ALU rd=1..4 held until accepted
    k = 1;
    for (int i = 0; i < 8; i++) begin
      bus.ld_valid  = (i < 4);
      bus.ld_rd     = 5'(10 + i);
      bus.ld_data   = 32'h10a + 32'(i);
      bus.alu_valid = (k <= 4);
      bus.alu_rd    = 5'(k);
      bus.alu_data  = 32'h200 + 32'(k);
      #1;
      if (i < 7)
        chk($sformatf("bp_ready%0d", i),
            32'(bus.alu_ready), 32'(exp_rdy[i]));
      acc = bus.alu_valid && bus.alu_ready;
      tick();
      if (acc) k++;
      chk_wr($sformatf("bp_wr%0d", i), exp_addr[i], exp_data[i]);
    end
    idle();
    chk("bp_all_acc", 32'(k), 32'd5);
    chk("bp_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("bp_we_drop", 32'(bus.write_enable), 32'd0);

    // x0 results are accepted and dropped
    for (int i = 0; i < 5; i++) begin
      bus.ld_valid  = 1'b1;
      bus.ld_rd     = 5'd0;
      bus.ld_data   = 32'hDEAD;
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'd0;
      bus.alu_data  = 32'hBEEF;
      #1;
      chk($sformatf("x0_ready%0d", i), 32'(bus.alu_ready), 32'd1);
      tick();
      chk($sformatf("x0_we%0d", i), 32'(bus.write_enable), 32'd0);
      chk($sformatf("x0_busy%0d", i), 32'(bus.busy), 32'd0);
    end
    idle();

    // Fill FIFO, then reset between edges
    bus.ld_valid  = 1'b1;
    bus.ld_rd     = 5'd20;
    bus.ld_data   = 32'h20;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd21;
    bus.alu_data  = 32'h21;
    tick();
    bus.ld_rd     = 5'd22;
    bus.ld_data   = 32'h22;
    bus.alu_rd    = 5'd23;
    bus.alu_data  = 32'h23;
    tick();
    idle();
    bus.query_addr1 = 5'd21;
    bus.query_addr2 = 5'd23;
    #1;
    chk_wr("full_ld", 5'd22, 32'h22);
    chk("full_ready", 32'(bus.alu_ready), 32'd0);
    chk("full_hit1", 32'(bus.query_hit1), 32'd1);
    chk("full_hit2", 32'(bus.query_hit2), 32'd1);
    rst = 1'b0;
    #1;
    chk("ar_we", 32'(bus.write_enable), 32'd0);
    chk("ar_addr", 32'(bus.write_addr), 32'd0);
    chk("ar_data", bus.write_data, 32'd0);
    chk("ar_busy", 32'(bus.busy), 32'd0);
    chk("ar_hit1", 32'(bus.query_hit1), 32'd0);
    chk("ar_hit2", 32'(bus.query_hit2), 32'd0);
    chk("ar_ready", 32'(bus.alu_ready), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("ar_rel_ready", 32'(bus.alu_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("ar_stale%0d", i),
          32'(bus.write_enable), 32'd0);
      chk($sformatf("ar_busy%0d", i), 32'(bus.busy), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
